// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGBW frame decoder: FSM state encoding,
// colour channel indices, frame limits and small frame-field helpers.
package rgbw_pkg;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned TO_W    = 16;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
  localparam logic [1:0] CH_W = 2'd3;

  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  // Command byte: sync nibble on top, reserved bits zero, start channel below.
  function automatic logic cmd_valid(input logic [7:0] b, input logic [3:0] sync);
    return (b[7:4] == sync) && (b[3:2] == 2'b00);
  endfunction

  // Length byte: 1..MAX_LEN data bytes.
  function automatic logic len_valid(input logic [7:0] b);
    return (b != 8'd0) && (b <= 8'(MAX_LEN));
  endfunction

endpackage

// File: rtl/rgbw_frame_decoder_timeout.sv
// frame_timeout: inter-byte watchdog counter.
// Ports: clk, reset (async, active-high), clr_i (restart count),
//        en_i (count this cycle), expire_c (count reached LIMIT-1 while enabled).
module frame_timeout
  import rgbw_pkg::*;
#(
  parameter int unsigned LIMIT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Clear wins over counting so a byte on the expiry cycle restarts the window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = en_i & ~clr_i & (cnt_q == TO_W'(LIMIT - 1));

endmodule

// File: rtl/rgbw_frame_decoder.sv
// rgbw_frame_decoder: parses CMD/LEN/DATA/CHK register-write frames from the
// SPI byte receiver and atomically commits written channels to the PWM duties.
// Ports: clk, reset (async, active-high), cs (active-low select), rdy/data
//        (byte handshake), red/green/blue/white (committed duties), update
//        (commit pulse), frame_err (sticky error), busy (mid-frame).
module rgbw_frame_decoder
  import rgbw_pkg::*;
#(
  parameter logic [3:0]  SYNC_NIBBLE    = 4'hA,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rdy,
  input  logic [7:0] data,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] white,
  output logic       update,
  output logic       frame_err,
  output logic       busy
);

  state_e            state_q, state_d;
  logic              rdy_q;
  logic [1:0]        ptr_q, ptr_d;
  logic [2:0]        rem_q, rem_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        shadow_q [NUM_CH];
  logic [7:0]        shadow_d [NUM_CH];
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [7:0]        duty_q [NUM_CH];
  logic [7:0]        duty_d [NUM_CH];
  logic              update_q, update_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic byte_stb;
  logic active;
  logic expire_c;

  // One strobe per rdy high period.
  assign byte_stb = rdy & ~rdy_q;
  assign active   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);

  frame_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (byte_stb | ~active),
    .en_i     (active),
    .expire_c (expire_c)
  );

  // Next-state: cs beats a byte, a byte beats the timeout.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    csum_d   = csum_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    duty_d   = duty_q;
    update_d = 1'b0;
    err_d    = err_q;

    if (cs) begin
      if (active) begin
        err_d   = 1'b1;
        mask_d  = '0;
        state_d = S_CMD;
      end else if (state_q == S_ERR) begin
        state_d = S_CMD;
      end
    end else if (byte_stb) begin
      case (state_q)
        S_CMD: begin
          if (cmd_valid(data, SYNC_NIBBLE)) begin
            ptr_d   = data[1:0];
            csum_d  = data;
            state_d = S_LEN;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        S_LEN: begin
          if (len_valid(data)) begin
            rem_d   = data[2:0];
            csum_d  = csum_q ^ data;
            state_d = S_DATA;
          end else begin
            err_d   = 1'b1;
            mask_d  = '0;
            state_d = S_ERR;
          end
        end
        S_DATA: begin
          shadow_d[ptr_q] = data;
          mask_d[ptr_q]   = 1'b1;
          csum_d          = csum_q ^ data;
          ptr_d           = ptr_q + 2'(1);
          rem_d           = rem_q - 3'(1);
          if (rem_q == 3'd1) begin
            state_d = S_CHK;
          end
        end
        S_CHK: begin
          // Only channels written in this frame reach the outputs.
          if (data == csum_q) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (mask_q[i]) begin
                duty_d[i] = shadow_q[i];
              end
            end
            update_d = 1'b1;
            err_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          mask_d  = '0;
          state_d = S_CMD;
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_CMD;
        end
      endcase
    end else if (expire_c) begin
      err_d   = 1'b1;
      mask_d  = '0;
      state_d = S_CMD;
    end

    busy_d = (state_d != S_CMD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_CMD;
      rdy_q    <= 1'b0;
      ptr_q    <= '0;
      rem_q    <= '0;
      csum_q   <= '0;
      shadow_q <= '{default: '0};
      mask_q   <= '0;
      duty_q   <= '{default: '0};
      update_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      csum_q   <= csum_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      duty_q   <= duty_d;
      update_q <= update_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign red       = duty_q[CH_R];
  assign green     = duty_q[CH_G];
  assign blue      = duty_q[CH_B];
  assign white     = duty_q[CH_W];
  assign update    = update_q;
  assign frame_err = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Testbench for rgbw_frame_decoder: table of frames with hand-derived
// results, a commit scoreboard checked on every update pulse, and
// sequences for protocol errors, cs abort, timeout and reset mid-frame.
module tb_rgbw_frame_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic       rdy;
  logic [7:0] data;
  logic [7:0] red, green, blue, white;
  logic       update, frame_err, busy;

  int checks   = 0;
  int failures = 0;
  int n_upd    = 0;

  always #5 clk = ~clk;

  rgbw_frame_decoder #(
    .SYNC_NIBBLE    (4'hA),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .rdy       (rdy),
    .data      (data),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .white     (white),
    .update    (update),
    .frame_err (frame_err),
    .busy      (busy)
  );

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] w;
  } duty_t;

  typedef struct {
    logic [6:0][7:0] bytes;  // first byte in [6]
    int              n;
    int              hold;
    int              upd;
    duty_t           exp;
    logic            err;
  } vec_t;

  duty_t sb_q[$];
  vec_t  vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every update pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (update === 1'b1) begin
      duty_t e;
      n_upd++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_update actual=%h required=none", {red, green, blue, white});
      end else begin
        e = sb_q.pop_front();
        check("sb_commit", {red, green, blue, white}, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Present one byte for 'hold' cycles, then two idle cycles.
  task automatic send_byte(input logic [7:0] b, input int hold);
    data = b;
    rdy  = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic cs_pulse();
    cs = 1'b1;
    @(posedge clk);
    #1 cs = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [55:0] b, input int n, input int hold,
                              input int upd, input logic [31:0] rgbw, input logic err);
    vec_t v;
    v.bytes = b;
    v.n     = n;
    v.hold  = hold;
    v.upd   = upd;
    v.exp   = rgbw;
    v.err   = err;
    return v;
  endfunction

  initial begin
    int n0;
    vecs[0] = mk(56'hA0_02_11_22_91_00_00, 5, 1, 1, 32'h11_22_00_00, 1'b0);
    vecs[1] = mk(56'hA3_02_33_44_D6_00_00, 5, 1, 1, 32'h44_22_00_33, 1'b0);
    vecs[2] = mk(56'hA0_01_55_00_00_00_00, 4, 1, 0, 32'h44_22_00_33, 1'b1);
    vecs[3] = mk(56'hA1_01_7F_DF_00_00_00, 4, 1, 1, 32'h44_7F_00_33, 1'b0);
    vecs[4] = mk(56'hA2_04_01_02_03_04_A2, 7, 1, 1, 32'h03_04_01_02, 1'b0);
    vecs[5] = mk(56'hA2_01_C3_60_00_00_00, 4, 1, 1, 32'h03_04_C3_02, 1'b0);
    vecs[6] = mk(56'hA0_01_5A_FB_00_00_00, 4, 3, 1, 32'h5A_04_C3_02, 1'b0);

    reset = 1'b1;
    cs    = 1'b0;
    rdy   = 1'b0;
    data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_duties", {red, green, blue, white}, 32'h0);
    check("reset_flags", {29'd0, update, frame_err, busy}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table of frames, state carried from one to the next.
    for (int i = 0; i < 7; i++) begin
      n0 = n_upd;
      if (vecs[i].upd != 0) sb_q.push_back(vecs[i].exp);
      for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].bytes[6-k], vecs[i].hold);
      check($sformatf("vec%0d_duties", i), {red, green, blue, white}, vecs[i].exp);
      check($sformatf("vec%0d_err", i), {31'd0, frame_err}, {31'd0, vecs[i].err});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
      check($sformatf("vec%0d_updates", i), n_upd - n0, vecs[i].upd);
    end

    // Illegal LEN: locked in S_ERR until cs pulses.
    n0 = n_upd;
    send_byte(8'hA0, 1);
    send_byte(8'h05, 1);
    check("len5_err", {30'd0, frame_err, busy}, 32'h3);
    send_byte(8'hA0, 1);
    send_byte(8'h01, 1);
    send_byte(8'h11, 1);
    send_byte(8'hB0, 1);
    check("err_ignores_bytes", {busy, 7'd0, red, 16'(n_upd - n0)}, {1'b1, 7'd0, 8'h5A, 16'd0});
    cs_pulse();
    check("err_cs_exit", {30'd0, frame_err, busy}, 32'h2);
    sb_q.push_back(32'h5A_04_C3_99);
    send_byte(8'hA3, 1);
    send_byte(8'h01, 1);
    send_byte(8'h99, 1);
    send_byte(8'h3B, 1);
    check("after_err_commit", {white, 23'd0, frame_err}, {8'h99, 24'd0});

    // Bad CMD.
    send_byte(8'h50, 1);
    check("cmd50_err", {30'd0, frame_err, busy}, 32'h3);
    send_byte(8'hA0, 1);
    check("cmd50_still_err", {31'd0, busy}, 32'h1);
    cs_pulse();
    check("cmd50_cs_exit", {31'd0, busy}, 32'h0);
    sb_q.push_back(32'h5A_10_C3_99);
    send_byte(8'hA1, 1);
    send_byte(8'h01, 1);
    send_byte(8'h10, 1);
    send_byte(8'hB0, 1);
    check("after_cmd50_commit", {green, 23'd0, frame_err}, {8'h10, 24'd0});

    // cs abort mid-frame: the partially written red must not leak later.
    n0 = n_upd;
    send_byte(8'hA0, 1);
    send_byte(8'h02, 1);
    send_byte(8'h11, 1);
    check("abort_busy_before", {31'd0, busy}, 32'h1);
    cs_pulse();
    check("abort_flags", {30'd0, frame_err, busy}, 32'h2);
    check("abort_no_commit", {red, 24'(n_upd - n0)}, {8'h5A, 24'd0});
    sb_q.push_back(32'h5A_10_77_99);
    send_byte(8'hA2, 1);
    send_byte(8'h01, 1);
    send_byte(8'h77, 1);
    send_byte(8'hD4, 1);
    check("abort_mask_cleared", {red, green, blue, white}, 32'h5A_10_77_99);

    // cs high together with a byte: byte discarded.
    cs   = 1'b1;
    rdy  = 1'b1;
    data = 8'hA0;
    @(posedge clk);
    #1 cs = 1'b0;
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("cs_beats_strobe", {31'd0, busy}, 32'h0);

    // Timeout: last strobe at E0, expiry acts at E100.
    send_byte(8'hA0, 1);
    send_byte(8'h02, 1);
    send_byte(8'h11, 1);
    repeat (96) @(posedge clk);
    @(negedge clk);
    check("timeout_not_yet", {30'd0, frame_err, busy}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("timeout_expired", {30'd0, frame_err, busy}, 32'h2);
    @(posedge clk);
    #1;

    // A strobe on the expiry cycle keeps the frame alive.
    send_byte(8'hA0, 1);
    send_byte(8'h02, 1);
    send_byte(8'h11, 1);
    repeat (97) @(posedge clk);
    #1 data = 8'h22;
    rdy = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("strobe_beats_timeout", {31'd0, busy}, 32'h1);
    sb_q.push_back(32'h11_22_77_99);
    send_byte(8'h91, 1);
    check("after_late_strobe", {red, green, 15'd0, frame_err}, {8'h11, 8'h22, 16'd0});

    // Reset mid-frame.
    send_byte(8'hA1, 1);
    send_byte(8'h01, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_duties", {red, green, blue, white}, 32'h0);
    check("midreset_flags", {29'd0, update, frame_err, busy}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    check("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
